// File: rtl/cpu_selftest_seq.sv
// Self-test sequencer for CPU_Pipeline_Fixed: loads a program into imem with the core held
// in reset, runs the core for a set number of cycles, then stalls it and checks registers.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start, core held in reset
// S_LOAD     | writing program slot imem_addr into imem, core in reset
// S_RUN      | core running, down-counter tracks the remaining cycles
// S_CHK_ADDR | core stalled, dbg_reg_addr driven for check entry cidx
// S_CHK_CMP  | compare debug read data against the expected value
// S_DONE     | results valid and held until the next start
module cpu_selftest_seq #(
  parameter int XLEN       = 32,
  parameter int PROG_DEPTH = 8,
  parameter int NUM_CHECKS = 4,
  parameter int RADDR_W    = 5,
  parameter int RUN_W      = 16,
  localparam int PIDX_W    = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1,
  localparam int CIDX_W    = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int FC_W      = $clog2(NUM_CHECKS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cfg_prog_we,
  input  logic [PIDX_W-1:0]  cfg_prog_idx,
  input  logic [XLEN-1:0]    cfg_prog_data,
  input  logic               cfg_chk_we,
  input  logic [CIDX_W-1:0]  cfg_chk_idx,
  input  logic [RADDR_W-1:0] cfg_chk_reg,
  input  logic [XLEN-1:0]    cfg_chk_val,
  input  logic [RUN_W-1:0]   run_cycles,
  output logic               imem_we,
  output logic [PIDX_W-1:0]  imem_addr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic               cpu_reset,
  output logic               cpu_stall,
  output logic [RADDR_W-1:0] dbg_reg_addr,
  input  logic [XLEN-1:0]    dbg_reg_data,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [FC_W-1:0]    fail_count,
  output logic [CIDX_W-1:0]  first_fail_idx,
  output logic [XLEN-1:0]    first_fail_val
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_CHK_ADDR, S_CHK_CMP, S_DONE
  } state_t;

  state_t             state_q;
  logic [XLEN-1:0]    slot_q      [PROG_DEPTH];
  logic [NUM_CHECKS-1:0] chk_valid_q;
  logic [RADDR_W-1:0] chk_reg_q   [NUM_CHECKS];
  logic [XLEN-1:0]    chk_val_q   [NUM_CHECKS];
  logic [CIDX_W-1:0]  cidx_q;
  logic [RUN_W-1:0]   run_len_q;
  logic [RUN_W-1:0]   run_cnt_q;
  logic               imem_we_q, cpu_reset_q, cpu_stall_q, busy_q, done_q, pass_q;
  logic [PIDX_W-1:0]  imem_addr_q;
  logic [XLEN-1:0]    imem_wdata_q, first_fail_val_q;
  logic [RADDR_W-1:0] dbg_reg_addr_q;
  logic [FC_W-1:0]    fail_count_q;
  logic [CIDX_W-1:0]  first_fail_idx_q;

  logic [XLEN-1:0]    exp_val;
  logic               mismatch, last_chk;
  logic [FC_W-1:0]    fail_count_d;
  logic [CIDX_W-1:0]  cidx_d;
  logic [PIDX_W-1:0]  pidx_d;
  logic [RUN_W-1:0]   run_len_m1;

  always_comb begin
    // x0 is hardwired to zero in the core, so its expectation is too
    exp_val      = (chk_reg_q[cidx_q] == '0) ? '0 : chk_val_q[cidx_q];
    mismatch     = (state_q == S_CHK_CMP) && (dbg_reg_data != exp_val);
    fail_count_d = fail_count_q;
    if (mismatch && (fail_count_q != FC_W'(NUM_CHECKS)))
      fail_count_d = fail_count_q + 1'b1;
    last_chk   = (cidx_q == CIDX_W'(NUM_CHECKS - 1));
    cidx_d     = cidx_q + 1'b1;
    pidx_d     = imem_addr_q + 1'b1;
    run_len_m1 = (run_len_q == '0) ? '0 : run_len_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      for (int i = 0; i < PROG_DEPTH; i++) slot_q[i] <= NOP;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        chk_reg_q[i] <= '0;
        chk_val_q[i] <= '0;
      end
      chk_valid_q      <= '0;
      cidx_q           <= '0;
      run_len_q        <= '0;
      run_cnt_q        <= '0;
      imem_we_q        <= 1'b0;
      imem_addr_q      <= '0;
      imem_wdata_q     <= '0;
      cpu_reset_q      <= 1'b1;
      cpu_stall_q      <= 1'b0;
      dbg_reg_addr_q   <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      fail_count_q     <= '0;
      first_fail_idx_q <= '0;
      first_fail_val_q <= '0;
    end else begin
      if (!busy_q) begin
        if (cfg_prog_we) slot_q[cfg_prog_idx] <= cfg_prog_data;
        if (cfg_chk_we) begin
          chk_valid_q[cfg_chk_idx] <= 1'b1;
          chk_reg_q[cfg_chk_idx]   <= cfg_chk_reg;
          chk_val_q[cfg_chk_idx]   <= cfg_chk_val;
        end
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            run_len_q        <= run_cycles;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            fail_count_q     <= '0;
            first_fail_idx_q <= '0;
            first_fail_val_q <= '0;
            busy_q           <= 1'b1;
            cpu_reset_q      <= 1'b1;
            cpu_stall_q      <= 1'b0;
            imem_we_q        <= 1'b1;
            imem_addr_q      <= '0;
            imem_wdata_q     <= slot_q[0];
            state_q          <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (imem_addr_q == PIDX_W'(PROG_DEPTH - 1)) begin
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b0;
            run_cnt_q    <= run_len_m1;
            state_q      <= S_RUN;
          end else begin
            imem_addr_q  <= pidx_d;
            imem_wdata_q <= slot_q[pidx_d];
          end
        end
        S_RUN: begin
          if (run_cnt_q == '0) begin
            cpu_stall_q    <= 1'b1;
            cidx_q         <= '0;
            dbg_reg_addr_q <= chk_reg_q[0];
            state_q        <= S_CHK_ADDR;
          end else begin
            run_cnt_q <= run_cnt_q - 1'b1;
          end
        end
        S_CHK_ADDR, S_CHK_CMP: begin
          fail_count_q <= fail_count_d;
          if (mismatch && (fail_count_q == '0)) begin
            first_fail_idx_q <= cidx_q;
            first_fail_val_q <= dbg_reg_data;
          end
          if ((state_q == S_CHK_ADDR) && chk_valid_q[cidx_q]) begin
            state_q <= S_CHK_CMP;
          end else if (last_chk) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_count_d == '0) && (|chk_valid_q);
            state_q <= S_DONE;
          end else begin
            cidx_q         <= cidx_d;
            dbg_reg_addr_q <= chk_reg_q[cidx_d];
            state_q        <= S_CHK_ADDR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_we        = imem_we_q;
  assign imem_addr      = imem_addr_q;
  assign imem_wdata     = imem_wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign cpu_stall      = cpu_stall_q;
  assign dbg_reg_addr   = dbg_reg_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_count     = fail_count_q;
  assign first_fail_idx = first_fail_idx_q;
  assign first_fail_val = first_fail_val_q;

endmodule

// File: doc/cpu_selftest_seq.md
Name: cpu_selftest_seq

Overview:
Parametrised, synthesizable self-test sequencer for CPU_Pipeline_Fixed. It loads a short program into instruction memory while holding the core in reset, then releases the core and runs it for a programmable cycle count. It then stalls the core, reads back a table of architectural registers over the debug read port, and reports pass/fail plus the first mismatch. It sits beside the core and replaces hand-poked memory and register checks with a hardware-driven, repeatable test.

Parameters:
XLEN, 32, data width of instruction words and registers
PROG_DEPTH, 8, number of program slots loaded into imem (words 0..PROG_DEPTH-1)
NUM_CHECKS, 4, number of expected-register table entries
RADDR_W, 5, register index width
RUN_W, 16, width of the run-cycle counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a test sequence
cfg_prog_we  in  1  write program slot
cfg_prog_idx  in  clog2(PROG_DEPTH)  program slot index
cfg_prog_data  in  XLEN  instruction word
cfg_chk_we  in  1  write check entry (sets its valid bit)
cfg_chk_idx  in  clog2(NUM_CHECKS)  check entry index
cfg_chk_reg  in  RADDR_W  register to check
cfg_chk_val  in  XLEN  expected value
run_cycles  in  RUN_W  core run length; sampled on start
imem_we  out  1  imem write strobe
imem_addr  out  clog2(PROG_DEPTH)  imem word index
imem_wdata  out  XLEN  imem write data
cpu_reset  out  1  active-high reset to core
cpu_stall  out  1  freezes core pipeline
dbg_reg_addr  out  RADDR_W  register-file debug read address
dbg_reg_data  in  XLEN  register-file debug read data (combinational from dbg_reg_addr)
busy  out  1  sequence in progress
done  out  1  results valid; held until next start
pass  out  1  all valid checks matched and at least one valid check exists
fail_count  out  clog2(NUM_CHECKS+1)  mismatch count
first_fail_idx  out  clog2(NUM_CHECKS)  index of first mismatching entry
first_fail_val  out  XLEN  actual value read at first mismatch

Behaviour:
- Reset (async assert, sync release): state IDLE; all program slots = 32'h00000013 (NOP); all check entries invalid; cpu_reset=1, cpu_stall=0, imem_we=0, imem_addr=0, imem_wdata=0, dbg_reg_addr=0, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=0, first_fail_val=0. Reset mid-sequence aborts and gives the same values.
- cfg writes are accepted only when busy=0 and are ignored while busy. Simultaneous prog and chk writes are both accepted.
- States: IDLE -> LOAD -> RUN -> CHK_ADDR/CHK_CMP -> DONE.
- IDLE/DONE + start: latch run_cycles, clear done/pass/fail_count/first_fail_*, busy=1, go to LOAD. start while busy is ignored.
- LOAD: PROG_DEPTH cycles, one slot per cycle. imem_we=1, imem_addr=k, imem_wdata=slot[k] for k=0..PROG_DEPTH-1. cpu_reset=1 throughout.
- RUN: imem_we=0, cpu_reset=0, cpu_stall=0 for max(run_cycles,1) cycles, then go to check.
- CHECK: cpu_stall=1 and cpu_reset=0 from here through DONE. Entries are scanned 0..NUM_CHECKS-1:
  - An invalid entry takes 1 cycle and is skipped.
  - A valid entry takes 2 cycles. CHK_ADDR drives dbg_reg_addr=reg. CHK_CMP compares dbg_reg_data with the expected value.
  - For reg 0, the expected value is forced to 0.
  - On mismatch: fail_count+1, saturating at NUM_CHECKS. On the first mismatch only, capture first_fail_idx and first_fail_val.
- DONE: busy=0, done=1, pass=(fail_count==0 && valid_count>0). Results hold until start or reset. Program and check tables persist across runs.
- Latency from start to done=1: 1 + PROG_DEPTH + max(run_cycles,1) + 2*valid + invalid cycles.

Test Plan:
- Slots 0..2 = 00A00093, 00500113, 002081B3, rest NOP. Checks {x1=0xA, x2=0x5, x3=0xF}, run_cycles=15, start -> done after 1+8+15+6+1=31 cycles, pass=1, fail_count=0.
- Same program with check x3 expected 0x10 at entry 2 -> pass=0, fail_count=1, first_fail_idx=2, first_fail_val=0x0000000F.
- No checks written, start -> done=1, pass=0, fail_count=0. LOAD shows imem_addr 0..7 with imem_wdata=00000013 for every unwritten slot.
- Assert reset (low) during RUN -> cpu_reset=1, busy=0, done=0 immediately. After release, the check table is invalid and the program slots are NOP.
- cfg_chk_we and start pulsed while busy -> table unchanged, sequence unaffected. A second start in DONE reruns and clears the prior results first.
- run_cycles=0 -> RUN lasts exactly 1 cycle (cpu_reset low for one cycle before cpu_stall rises). Check of x0 with expected 5 still compares against 0 -> pass=1.
